// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - J/K excitation driver with Q feedback check; JK_DRIVER_STICKY_ERR_EN adds a halting sticky error
module jk_excitation_driver #(
  parameter int CNT_W          = 8,
  parameter bit DONT_CARE_FILL = 1'b0
) (
  input  logic             clockPulse,
  input  logic             resetN,
  input  logic             target,
  input  logic             targetValid,
  output logic             targetReady,
  output logic             J,
  output logic             K,
  input  logic             Q,
  output logic             mismatch,
  output logic [CNT_W-1:0] errorCount,
  output logic             busy,
  output logic             errorSticky
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t state;
  logic   expected;

`ifdef JK_DRIVER_STICKY_ERR_EN
  logic sticky_q;
  assign errorSticky = sticky_q;
  // A latched failure halts acceptance until the next reset.
  assign targetReady = (state == IDLE) && !sticky_q;
`else
  assign errorSticky = 1'b0;
  assign targetReady = (state == IDLE);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      expected   <= 1'b0;
      J          <= 1'b0;
      K          <= 1'b0;
      mismatch   <= 1'b0;
      errorCount <= '0;
`ifdef JK_DRIVER_STICKY_ERR_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          J <= 1'b0;
          K <= 1'b0;
          if (targetValid && targetReady) begin
            expected <= target;
            // Excitation table: only the input that matters is driven, the other gets the fill value.
            if (Q) begin
              J <= DONT_CARE_FILL;
              K <= !target;
            end else begin
              J <= target;
              K <= DONT_CARE_FILL;
            end
            state <= DRIVE;
          end
        end
        DRIVE: begin
          J     <= 1'b0;
          K     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          J <= 1'b0;
          K <= 1'b0;
          if (Q != expected) begin
            mismatch <= 1'b1;
            if (errorCount != {CNT_W{1'b1}})
              errorCount <= errorCount + CNT_W'(1);
`ifdef JK_DRIVER_STICKY_ERR_EN
            sticky_q <= 1'b1;
`endif
          end
          state <= IDLE;
        end
        default: begin
          J     <= 1'b0;
          K     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - directed bench: three driver instances each driving a modelled JK flip-flop
module tb_jk_excitation_driver;

`ifdef JK_DRIVER_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clockPulse = 1'b0;
  logic       resetN, target, targetValid;
  logic       j0, k0, j1, k1, j2, k2;
  logic       q0, q1, q2;
  logic       rdy0, rdy1, rdy2, mm0, mm1, mm2;
  logic       busy0, busy1, busy2, st0, st1, st2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       ff_clr, stuck;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clockPulse = ~clockPulse;

  jk_excitation_driver #(.CNT_W(8), .DONT_CARE_FILL(1'b0)) dut0 (
    .clockPulse(clockPulse), .resetN(resetN), .target(target), .targetValid(targetValid),
    .targetReady(rdy0), .J(j0), .K(k0), .Q(q0), .mismatch(mm0), .errorCount(cnt0),
    .busy(busy0), .errorSticky(st0));

  jk_excitation_driver #(.CNT_W(8), .DONT_CARE_FILL(1'b1)) dut1 (
    .clockPulse(clockPulse), .resetN(resetN), .target(target), .targetValid(targetValid),
    .targetReady(rdy1), .J(j1), .K(k1), .Q(q1), .mismatch(mm1), .errorCount(cnt1),
    .busy(busy1), .errorSticky(st1));

  jk_excitation_driver #(.CNT_W(2), .DONT_CARE_FILL(1'b0)) dut2 (
    .clockPulse(clockPulse), .resetN(resetN), .target(target), .targetValid(targetValid),
    .targetReady(rdy2), .J(j2), .K(k2), .Q(q2), .mismatch(mm2), .errorCount(cnt2),
    .busy(busy2), .errorSticky(st2));

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return !q;
      default: return q;
    endcase
  endfunction

  // Behavioural JK flip-flops on the shared clock; stuck forces Q low.
  always @(posedge clockPulse) begin
    q0 <= (ff_clr || stuck) ? 1'b0 : jk_next(q0, j0, k0);
    q1 <= (ff_clr || stuck) ? 1'b0 : jk_next(q1, j1, k1);
    q2 <= (ff_clr || stuck) ? 1'b0 : jk_next(q2, j2, k2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clockPulse);
    #1;
  endtask

  task automatic run_txn(input logic t, input logic [1:0] jk0, input logic [1:0] jk1,
                         input logic qe, input logic mm, input logic [7:0] c0, input logic [1:0] c2);
    target      = t;
    targetValid = 1'b1;
    chk("ready_accept", rdy0, 1'b1);
    step();
    targetValid = 1'b0;
    chk("jk_dut0", {j0, k0}, jk0);
    chk("jk_dut1", {j1, k1}, jk1);
    chk("jk_dut2", {j2, k2}, jk0);
    chk("busy_drive", busy0, 1'b1);
    chk("ready_drive", rdy0, 1'b0);
    step();
    chk("jk_zero_check", {j0, k0, j1, k1}, 4'b0000);
    chk("q_dut0", q0, qe);
    chk("q_dut1", q1, qe);
    chk("mm_not_early", mm0, 1'b0);
    step();
    chk("mm_dut0", mm0, mm);
    chk("mm_dut1", mm1, mm);
    chk("mm_dut2", mm2, mm);
    chk("cnt_dut0", cnt0, c0);
    chk("cnt_dut1", cnt1, c0);
    chk("cnt_dut2", cnt2, c2);
    chk("ready_again", rdy0, !(STICKY && mm));
    chk("busy_idle", busy0, 1'b0);
  endtask

  initial begin
    resetN      = 1'b0;
    target      = 1'b0;
    targetValid = 1'b0;
    ff_clr      = 1'b1;
    stuck       = 1'b0;
    step();
    step();
    chk("rst_ready", {rdy0, rdy1, rdy2}, 3'b111);
    chk("rst_jk", {j0, k0, j1, k1, j2, k2}, 6'b0);
    chk("rst_mm", {mm0, mm1, mm2}, 3'b0);
    chk("rst_busy", {busy0, busy1, busy2}, 3'b0);
    chk("rst_sticky", {st0, st1, st2}, 3'b0);
    chk("rst_cnt", {cnt0, cnt1, cnt2}, 18'd0);
    resetN = 1'b1;
    ff_clr = 1'b0;

    // Reset arriving mid-DRIVE clears outputs without a clock edge.
    target      = 1'b1;
    targetValid = 1'b1;
    step();
    targetValid = 1'b0;
    chk("middrive_j", j0, 1'b1);
    resetN = 1'b0;
    #1;
    chk("async_jk", {j0, k0}, 2'b00);
    chk("async_ready", rdy0, 1'b1);
    chk("async_busy", busy0, 1'b0);
    chk("async_cnt", cnt0, 8'd0);
    #2;
    resetN = 1'b1;
    ff_clr = 1'b1;
    step();
    ff_clr = 1'b0;
    chk("q_init", {q0, q1}, 2'b00);

    // Targets 0,1,1,0,0 from Q=0 with both don't-care fills.
    run_txn(1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'd0);
    run_txn(1'b1, 2'b10, 2'b11, 1'b1, 1'b0, 8'd0, 2'd0);
    run_txn(1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'd0, 2'd0);
    run_txn(1'b0, 2'b01, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0);
    run_txn(1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'd0);

    // Q stuck low: first failing transaction.
    stuck = 1'b1;
    run_txn(1'b1, 2'b10, 2'b11, 1'b0, 1'b1, 8'd1, 2'd1);
    chk("sticky_flag", {st0, st1, st2}, {3{STICKY}});
    step();
    chk("mm_one_cycle", mm0, 1'b0);

`ifdef JK_DRIVER_STICKY_ERR_EN
    targetValid = 1'b1;
    target      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_ready", rdy0, 1'b0);
      chk("halt_busy", busy0, 1'b0);
      chk("halt_jk", {j0, k0}, 2'b00);
      chk("halt_sticky", st0, 1'b1);
    end
    targetValid = 1'b0;
    resetN = 1'b0;
    #1;
    chk("sticky_cleared", st0, 1'b0);
    chk("ready_restored", rdy0, 1'b1);
    #2;
    resetN = 1'b1;
    step();
    chk("ready_after_rst", rdy0, 1'b1);
`else
    // Four more failures: 2-bit counter saturates at 3.
    for (int i = 2; i <= 5; i++) begin
      run_txn(1'b1, 2'b10, 2'b11, 1'b0, 1'b1, 8'(i), (i > 3) ? 2'd3 : 2'(i));
    end
    chk("no_sticky", {st0, st1, st2}, 3'b000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
